// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl: push-button dice sequencer with roll, deceleration and latched result
module dice_roll_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int N_DECEL  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       boton,
    output logic [3:0] numero,
    output logic       rodando,
    output logic       listo
);
    localparam int DW = $clog2(TICK_DIV * (N_DECEL + 1)) + 1;
    localparam int SW = $clog2(N_DECEL + 1);
    typedef enum logic [1:0] {IDLE, ROLL, DECEL, SHOW} state_t;
    state_t state, state_n;
    logic [DW-1:0] divcnt, divcnt_n;
    logic [SW-1:0] step, step_n;
    logic [3:0] numero_n, numero_adv;
    logic boton_prev, press, tick_roll, tick_decel, last_step;
    assign press      = boton & ~boton_prev;
    assign numero_adv = (numero == 4'd6) ? 4'd1 : numero + 4'd1;
    assign tick_roll  = divcnt == DW'(TICK_DIV - 1);
    assign tick_decel = divcnt == DW'(TICK_DIV * (int'(step) + 2) - 1);
    assign last_step  = step == SW'(N_DECEL - 1);
    // next state and next datapath values; release in ROLL wins over a terminal tick
    always_comb begin
        state_n  = state;
        divcnt_n = divcnt;
        step_n   = step;
        numero_n = numero;
        case (state)
            IDLE: begin
                state_n  = press ? ROLL : IDLE;
                numero_n = press ? 4'd1 : numero;
                divcnt_n = '0;
            end
            ROLL: begin
                state_n  = boton ? ROLL : DECEL;
                step_n   = boton ? step : '0;
                numero_n = (boton && tick_roll) ? numero_adv : numero;
                divcnt_n = (!boton || tick_roll) ? '0 : divcnt + DW'(1);
            end
            DECEL: begin
                state_n  = (tick_decel && last_step) ? SHOW : DECEL;
                step_n   = tick_decel ? step + SW'(1) : step;
                numero_n = tick_decel ? numero_adv : numero;
                divcnt_n = tick_decel ? '0 : divcnt + DW'(1);
            end
            default: begin
                state_n  = press ? ROLL : SHOW;
                divcnt_n = '0;
            end
        endcase
    end
    // state and output registers; listo marks only the DECEL->SHOW edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            numero     <= '0;
            divcnt     <= '0;
            step       <= '0;
            boton_prev <= 1'b0;
            rodando    <= 1'b0;
            listo      <= 1'b0;
        end else begin
            state      <= state_n;
            numero     <= numero_n;
            divcnt     <= divcnt_n;
            step       <= step_n;
            boton_prev <= boton;
            rodando    <= (state_n == ROLL) || (state_n == DECEL);
            listo      <= (state == DECEL) && (state_n == SHOW);
        end
    end
endmodule
